// File: rtl/tcdm_bridge_pkg.sv
// tcdm_bridge_pkg: shared widths and payload sizing for the TCDM bridge request buffer
package tcdm_bridge_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W = 16;
  localparam int AUX_W = 32;
  localparam int DEPTH_DEF = 2;
  localparam int MAX_OUT_DEF = 8;
  function automatic int payload_width(input int addr, input int data, input int be, input int id, input int aux);
    return 1 + addr + 1 + data + be + id + aux;
  endfunction
endpackage

// File: rtl/tcdm_bridge_fifo.sv
// tcdm_bridge_fifo: flat-vector FIFO with wrap-bit pointers and cleared storage on reset
module tcdm_bridge_fifo
  import tcdm_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage and pointers; a full FIFO ignores push regardless of a same-cycle pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
endmodule

// File: rtl/tcdm_bridge_req_buffer.sv
// tcdm_bridge_req_buffer: elastic TCDM request buffer; TCDM_BRIDGE_OUTSTANDING_LIMIT_EN enables the in-flight cap
module tcdm_bridge_req_buffer
  import tcdm_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = ID_W,
  parameter int AUX_WIDTH = AUX_W,
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 data_req_i,
  input  logic                                 data_ts_set_i,
  input  logic [ADDR_WIDTH-1:0]                data_add_i,
  input  logic                                 data_wen_i,
  input  logic [DATA_WIDTH-1:0]                data_wdata_i,
  input  logic [BE_WIDTH-1:0]                  data_be_i,
  input  logic [ID_WIDTH-1:0]                  data_ID_i,
  input  logic [AUX_WIDTH-1:0]                 data_aux_i,
  output logic                                 data_gnt_o,
  output logic                                 data_req_o,
  output logic                                 data_ts_set_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  output logic [AUX_WIDTH-1:0]                 data_aux_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);
  localparam int PW = payload_width(ADDR_WIDTH, DATA_WIDTH, BE_WIDTH, ID_WIDTH, AUX_WIDTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [PW-1:0] din, dout;
  logic full, empty, push, pop, credit_ok;
  assign din = {data_ts_set_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i};
  assign {data_ts_set_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o} = dout;
  assign data_gnt_o = !full;
  assign push = data_req_i && data_gnt_o;
  assign data_req_o = !empty && credit_ok;
  assign pop = data_req_o && data_gnt_i;
  tcdm_bridge_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout), .full(full), .empty(empty)
  );
`ifdef TCDM_BRIDGE_OUTSTANDING_LIMIT_EN
  assign credit_ok = outstanding_o < OW'(MAX_OUTSTANDING);
  // in-flight counter: +1 per pop, -1 per response, saturates at 0 and flags a stray response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      outstanding_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (data_r_valid_i && outstanding_o == '0) err_o <= 1'b1;
      outstanding_o <= (pop && !data_r_valid_i) ? outstanding_o + OW'(1) :
                       (data_r_valid_i && !pop && outstanding_o != '0) ? outstanding_o - OW'(1) : outstanding_o;
    end
`else
  logic unused_r_valid;
  assign unused_r_valid = data_r_valid_i;
  assign credit_ok = 1'b1;
  assign outstanding_o = '0;
  assign err_o = 1'b0;
`endif
endmodule
